// File: rtl/mdio_pkg.sv
// Shared definitions for the Clause-22 MDIO master: FSM encoding, opcodes
// and frame field positions inside the 32-bit t_data word.
package mdio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRE   = 2'd1,
    ST_FRAME = 2'd2,
    ST_DONE  = 2'd3
  } mdio_state_e;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] ST_C22   = 2'b01;

  // Frame field positions (bit 31 goes on the wire first)
  localparam int FRAME_BITS = 32;
  localparam int ST_MSB     = 31;
  localparam int OP_MSB     = 29;
  localparam int OP_LSB     = 28;
  localparam int PHYAD_MSB  = 27;
  localparam int REGAD_MSB  = 22;
  localparam logic [5:0] TA_MSB   = 6'd17;
  localparam logic [5:0] DATA_MSB = 6'd15;

  // Master drives the line for every bit except TA+DATA of a read.
  function automatic logic drives_bit(input logic [1:0] op, input logic [5:0] bit_idx);
    return !((op == OP_READ) && (bit_idx <= TA_MSB));
  endfunction

endpackage

// File: rtl/mdio_clk_div.sv
// MDC generator: one bit period is MDC_DIV clk cycles, low half then high half.
// fall_en_o marks the final cycle of a period, so anything registered on it
// changes together with MDC falling. rise_en_o marks the first MDC-high cycle.
module mdio_clk_div #(
  parameter int MDC_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic mdc_o,
  output logic fall_en_o,
  output logic rise_en_o
);

  localparam int CW = (MDC_DIV > 2) ? $clog2(MDC_DIV) : 1;
  localparam logic [CW-1:0] HALF = CW'(MDC_DIV / 2);
  localparam logic [CW-1:0] LAST = CW'(MDC_DIV - 1);

  logic [CW-1:0] cnt_q;

  // Phase counter, parked at 0 whenever the master is not clocking a frame
  always_ff @(posedge clk) begin
    if (reset || !en_i)   cnt_q <= '0;
    else if (cnt_q == LAST) cnt_q <= '0;
    else                  cnt_q <= cnt_q + 1'b1;
  end

  assign mdc_o     = en_i && (cnt_q >= HALF);
  assign fall_en_o = en_i && (cnt_q == LAST);
  assign rise_en_o = en_i && (cnt_q == HALF);

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: preamble of ones, then a 32-bit frame MSB first.
// Reads release the line for TA+DATA and shift PHY data in on MDC rising.
module mdio_master
  import mdio_pkg::*;
#(
  parameter int MDC_DIV      = 4,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdio_start,
  input  logic [31:0] t_data,
  input  logic        mdio_in,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_oe,
  output logic        mdio_done,
  output logic [15:0] rd_data,
  output logic        busy
);

  localparam int PW = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PREAMBLE_LEN - 1);

  mdio_state_e   state_q;
  logic [31:0]   sh_q;
  logic [1:0]    op_q;
  logic [5:0]    bit_q;
  logic [PW-1:0] pre_q;
  logic          out_q, oe_q, done_q, busy_q;
  logic [15:0]   rd_q;
  logic          clk_en, fall_en, rise_en;

  assign clk_en = (state_q == ST_PRE) || (state_q == ST_FRAME);

  mdio_clk_div #(.MDC_DIV(MDC_DIV)) u_div (
    .clk       (clk),
    .reset     (reset),
    .en_i      (clk_en),
    .mdc_o     (mdc),
    .fall_en_o (fall_en),
    .rise_en_o (rise_en)
  );

  // Transaction FSM; all line outputs are registered and change on period ends
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      op_q    <= '0;
      bit_q   <= '0;
      pre_q   <= '0;
      out_q   <= 1'b1;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      rd_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (mdio_start) begin
            sh_q    <= t_data;
            op_q    <= t_data[OP_MSB:OP_LSB];
            pre_q   <= '0;
            bit_q   <= '0;
            out_q   <= 1'b1;
            oe_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_PRE;
          end
        end
        ST_PRE: begin
          if (fall_en) begin
            if (pre_q == PRE_LAST) begin
              state_q <= ST_FRAME;
              bit_q   <= 6'd31;
              out_q   <= sh_q[31];
              oe_q    <= 1'b1;
            end else begin
              pre_q <= pre_q + 1'b1;
            end
          end
        end
        ST_FRAME: begin
          if (rise_en && (op_q == OP_READ) && (bit_q <= DATA_MSB))
            rd_q <= {rd_q[14:0], mdio_in};
          if (fall_en) begin
            if (bit_q == 6'd0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              oe_q    <= 1'b0;
              out_q   <= 1'b1;
            end else begin
              sh_q  <= {sh_q[30:0], 1'b0};
              out_q <= sh_q[30];
              bit_q <= bit_q - 6'd1;
              oe_q  <= drives_bit(op_q, bit_q - 6'd1);
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mdio_out  = out_q;
  assign mdio_oe   = oe_q;
  assign mdio_done = done_q;
  assign busy      = busy_q;
  assign rd_data   = rd_q;

endmodule
